// File: rtl/ising_run_ctrl.sv
// Run sequencer for the coupled-oscillator Ising array: oscillator reset hold,
// timed free run, synchronised spin capture, and AXI weight-write gating.
module ising_run_ctrl #(
  parameter int N           = 8,
  parameter int CNT_W       = 32,
  parameter int RST_CYCLES  = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             axi_rst,
  input  logic             start,
  input  logic             abort,
  input  logic [CNT_W-1:0] run_cycles,
  output logic             busy,
  output logic             done,
  output logic [N-1:0]     result,
  output logic             result_valid,
  output logic             ising_rstn,
  input  logic [N-1:0]     spin_in,
  input  logic             wready_in,
  output logic             wready_out,
  output logic             wr_reject
);

  typedef enum logic [1:0] {S_IDLE, S_HOLD, S_RUN, S_SAMPLE} state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic [CNT_W-1:0] r_len_m1;
  logic [CNT_W-1:0] w_len_m1;
  logic             w_accept;
  logic             w_capture;
  logic [N-1:0]     r_sync [SYNC_STAGES];
  logic [N-1:0]     w_s;

  logic             r_busy;
  logic             r_done;
  logic [N-1:0]     r_result;
  logic             r_result_valid;
  logic             r_ising_rstn;
  logic             r_wr_reject;

  // Storing len-1 keeps the reload in range even for run_cycles = 2^CNT_W-1.
  assign w_len_m1 = (run_cycles == '0) ? '0 : run_cycles - CNT_W'(1);
  assign w_s      = r_sync[SYNC_STAGES-1];

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_accept    = 1'b0;
    w_capture   = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start && !abort) begin
          w_accept    = 1'b1;
          w_cnt_nxt   = CNT_W'(RST_CYCLES - 1);
          w_state_nxt = S_HOLD;
        end
      end
      S_HOLD: begin
        if (abort) begin
          w_state_nxt = S_IDLE;
        end else if (r_cnt == '0) begin
          w_cnt_nxt   = r_len_m1;
          w_state_nxt = S_RUN;
        end else begin
          w_cnt_nxt   = r_cnt - CNT_W'(1);
        end
      end
      S_RUN: begin
        if (abort) begin
          w_state_nxt = S_IDLE;
        end else if (r_cnt == '0) begin
          w_state_nxt = S_SAMPLE;
        end else begin
          w_cnt_nxt   = r_cnt - CNT_W'(1);
        end
      end
      S_SAMPLE: begin
        w_state_nxt = S_IDLE;
        w_capture   = !abort;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Outputs are registered from the next state so they line up with the state itself.
  always_ff @(posedge clk) begin
    if (axi_rst) begin
      r_state        <= S_IDLE;
      r_cnt          <= '0;
      r_len_m1       <= '0;
      r_busy         <= 1'b0;
      r_done         <= 1'b0;
      r_result       <= '0;
      r_result_valid <= 1'b0;
      r_ising_rstn   <= 1'b0;
      r_wr_reject    <= 1'b0;
      for (int k = 0; k < SYNC_STAGES; k++) r_sync[k] <= '0;
    end else begin
      r_state      <= w_state_nxt;
      r_cnt        <= w_cnt_nxt;
      r_busy       <= (w_state_nxt != S_IDLE);
      r_ising_rstn <= (w_state_nxt == S_RUN) || (w_state_nxt == S_SAMPLE);
      r_done       <= w_capture;
      r_wr_reject  <= wready_in & r_busy;
      r_sync[0]    <= spin_in;
      for (int k = 1; k < SYNC_STAGES; k++) r_sync[k] <= r_sync[k-1];
      if (w_accept) begin
        r_len_m1       <= w_len_m1;
        r_result_valid <= 1'b0;
      end
      if (w_capture) begin
        r_result       <= w_s ^ {N{w_s[0]}};
        r_result_valid <= 1'b1;
      end
    end
  end

  assign busy         = r_busy;
  assign done         = r_done;
  assign result       = r_result;
  assign result_valid = r_result_valid;
  assign ising_rstn   = r_ising_rstn;
  assign wr_reject    = r_wr_reject;
  assign wready_out   = wready_in & ~r_busy;

endmodule

// File: tb/tb_ising_run_ctrl.sv
// Bench for ising_run_ctrl: table-driven run scenarios, hand sequences for
// write gating / reset / long runs, and randomized traffic against a run-time model.
module tb_ising_run_ctrl;
  localparam int N     = 8;
  localparam int CNT_W = 32;
  localparam int RST   = 16;
  localparam int SYNC  = 2;

  logic             clk = 1'b0;
  logic             axi_rst = 1'b1;
  logic             start = 1'b0;
  logic             abort = 1'b0;
  logic [CNT_W-1:0] run_cycles = '0;
  logic             busy, done, result_valid, ising_rstn, wready_out, wr_reject;
  logic [N-1:0]     result;
  logic [N-1:0]     spin_in = '0;
  logic             wready_in = 1'b0;

  always #5 clk = ~clk;

  ising_run_ctrl #(.N(N), .CNT_W(CNT_W), .RST_CYCLES(RST), .SYNC_STAGES(SYNC)) dut (
    .clk(clk), .axi_rst(axi_rst), .start(start), .abort(abort), .run_cycles(run_cycles),
    .busy(busy), .done(done), .result(result), .result_valid(result_valid),
    .ising_rstn(ising_rstn), .spin_in(spin_in), .wready_in(wready_in),
    .wready_out(wready_out), .wr_reject(wr_reject)
  );

  int total = 0;
  int bad   = 0;

  // Model: a run is "active" with k = cycles elapsed since the accepting edge.
  logic         m_busy = 1'b0, m_done = 1'b0, m_rv = 1'b0, m_wrrej = 1'b0, m_rstn = 1'b0;
  logic [N-1:0] m_res = '0;
  longint       m_k = 0, m_len = 0;
  logic [N-1:0] hist [SYNC];
  logic         g_wout;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_edge();
    logic [N-1:0] cap;
    if (axi_rst) begin
      m_busy = 0; m_done = 0; m_rv = 0; m_wrrej = 0; m_res = '0; m_k = 0;
      for (int i = 0; i < SYNC; i++) hist[i] = '0;
    end else begin
      m_wrrej = wready_in & m_busy;
      m_done  = 0;
      cap     = hist[SYNC-1];
      for (int i = SYNC-1; i > 0; i--) hist[i] = hist[i-1];
      hist[0] = spin_in;
      if (m_busy) begin
        if (abort) m_busy = 0;
        else begin
          m_k++;
          if (m_k == RST + m_len + 1) begin
            m_busy = 0; m_done = 1; m_rv = 1;
            m_res  = cap ^ {N{cap[0]}};
          end
        end
      end else if (start && !abort) begin
        m_busy = 1; m_k = 0; m_rv = 0;
        m_len  = (run_cycles == 0) ? 1 : longint'(run_cycles);
      end
    end
    m_rstn = m_busy && (m_k >= RST);
  endtask

  task automatic cyc(input logic st, input logic ab, input logic rs, input logic wr,
                     input logic [CNT_W-1:0] rc, input logic [N-1:0] sp);
    start = st; abort = ab; axi_rst = rs; wready_in = wr; run_cycles = rc; spin_in = sp;
    #2;
    g_wout = wready_out;
    check("wready_out", {63'd0, wready_out}, {63'd0, wr & ~m_busy});
    @(posedge clk);
    model_edge();
    #1;
    check("busy",         {63'd0, busy},         {63'd0, m_busy});
    check("done",         {63'd0, done},         {63'd0, m_done});
    check("ising_rstn",   {63'd0, ising_rstn},   {63'd0, m_rstn});
    check("result",       {56'd0, result},       {56'd0, m_res});
    check("result_valid", {63'd0, result_valid}, {63'd0, m_rv});
    check("wr_reject",    {63'd0, wr_reject},    {63'd0, m_wrrej});
  endtask

  typedef struct {
    string            nm;
    logic [CNT_W-1:0] rc;
    logic [N-1:0]     sp;
    int               abort_at;
    int               exp_lat;
    int               exp_busy;
    int               exp_lo;
    int               exp_hi;
    logic [N-1:0]     exp_res;
    logic             exp_rv;
  } tcase_t;

  tcase_t tbl [6];

  task automatic run_case(input tcase_t c);
    int lat = -1, nbusy = 0, nlo = 0, nhi = 0, ndone = 0;
    repeat (3) cyc(0, 0, 0, 0, c.rc, c.sp);
    cyc(1, 0, 0, 0, c.rc, c.sp);
    if (busy) nbusy++;
    if (busy && !ising_rstn) nlo++;
    if (ising_rstn) nhi++;
    for (int i = 0; i < 60; i++) begin
      cyc(0, (i == c.abort_at), 0, 0, c.rc, c.sp);
      if (done) begin ndone++; if (lat < 0) lat = i + 1; end
      if (busy) nbusy++;
      if (busy && !ising_rstn) nlo++;
      if (ising_rstn) nhi++;
    end
    check({c.nm, "_latency"},  64'(lat),   64'(c.exp_lat));
    check({c.nm, "_ndone"},    64'(ndone), 64'((c.exp_lat < 0) ? 0 : 1));
    check({c.nm, "_busycyc"},  64'(nbusy), 64'(c.exp_busy));
    check({c.nm, "_rstn_lo"},  64'(nlo),   64'(c.exp_lo));
    check({c.nm, "_rstn_hi"},  64'(nhi),   64'(c.exp_hi));
    check({c.nm, "_result"},   {56'd0, result}, {56'd0, c.exp_res});
    check({c.nm, "_rvalid"},   {63'd0, result_valid}, {63'd0, c.exp_rv});
  endtask

  initial begin
    int lat, nrej, nwout, nlo, nhi;
    for (int i = 0; i < SYNC; i++) hist[i] = '0;
    tbl[0] = '{"t1_len10",  32'd10, 8'h00, -1, 27, 27, 16, 11, 8'h00, 1'b1};
    tbl[1] = '{"t2_a5",     32'd5,  8'hA5, -1, 22, 22, 16, 6,  8'h5A, 1'b1};
    tbl[2] = '{"t2_5a",     32'd5,  8'h5A, -1, 22, 22, 16, 6,  8'h5A, 1'b1};
    tbl[3] = '{"t3_len0",   32'd0,  8'h0F, -1, 18, 18, 16, 2,  8'hF0, 1'b1};
    tbl[4] = '{"t3_len1",   32'd1,  8'h0F, -1, 18, 18, 16, 2,  8'hF0, 1'b1};
    tbl[5] = '{"t4_abort",  32'd10, 8'h33, 20, -1, 21, 16, 5,  8'hF0, 1'b0};

    // Reset state
    cyc(0, 0, 1, 0, 0, 8'hFF);
    cyc(0, 0, 1, 1, 0, 8'hFF);
    check("rst_busy",   {63'd0, busy},       64'd0);
    check("rst_rstn",   {63'd0, ising_rstn}, 64'd0);
    check("rst_result", {56'd0, result},     64'd0);
    check("rst_rvalid", {63'd0, result_valid}, 64'd0);

    foreach (tbl[i]) run_case(tbl[i]);

    // Write gating and start-while-busy
    lat = -1; nrej = 0; nwout = 0;
    cyc(0, 0, 0, 1, 32'd10, 8'h00); if (g_wout) nwout++;
    cyc(0, 0, 0, 0, 32'd10, 8'h00);
    cyc(1, 0, 0, 0, 32'd10, 8'h00);
    for (int i = 0; i < 40; i++) begin
      cyc((i == 22), 0, 0, (i == 3 || i == 20), 32'd3, 8'h00);
      if (g_wout) nwout++;
      if (wr_reject) nrej++;
      if (done && lat < 0) lat = i + 1;
    end
    check("t5_wready_out_cnt", 64'(nwout), 64'd1);
    check("t5_wr_reject_cnt",  64'(nrej),  64'd2);
    check("t5_latency",        64'(lat),   64'd27);

    // Reset in the middle of a run, then a fresh run with a same-cycle write
    cyc(1, 0, 0, 0, 32'd10, 8'h81);
    repeat (20) cyc(0, 0, 0, 0, 32'd10, 8'h81);
    cyc(0, 0, 1, 0, 32'd10, 8'h81);
    check("t6_busy",   {63'd0, busy},         64'd0);
    check("t6_rstn",   {63'd0, ising_rstn},   64'd0);
    check("t6_result", {56'd0, result},       64'd0);
    check("t6_rvalid", {63'd0, result_valid}, 64'd0);
    cyc(0, 0, 0, 0, 32'd10, 8'h81);
    cyc(1, 0, 0, 1, 32'd10, 8'h81);
    check("t6_start_write_passes", {63'd0, g_wout}, 64'd1);
    lat = -1; nlo = (busy && !ising_rstn) ? 1 : 0; nhi = 0;
    for (int i = 0; i < 40; i++) begin
      cyc(0, 0, 0, 0, 32'd10, 8'h81);
      if (busy && !ising_rstn) nlo++;
      if (ising_rstn) nhi++;
      if (done && lat < 0) lat = i + 1;
    end
    check("t6_latency", 64'(lat), 64'd27);
    check("t6_rstn_lo", 64'(nlo), 64'd16);
    check("t6_rstn_hi", 64'(nhi), 64'd11);
    check("t6_result_after", {56'd0, result}, 64'h7E);

    // Maximum run length must not wrap to a short run
    cyc(1, 0, 0, 0, 32'hFFFF_FFFF, 8'h00);
    repeat (100) cyc(0, 0, 0, 0, 32'hFFFF_FFFF, 8'h00);
    check("max_len_busy", {63'd0, busy},       64'd1);
    check("max_len_rstn", {63'd0, ising_rstn}, 64'd1);
    cyc(0, 1, 0, 0, 32'hFFFF_FFFF, 8'h00);
    check("max_len_abort", {63'd0, busy}, 64'd0);

    // Randomized traffic against the model
    for (int i = 0; i < 4000; i++) begin
      cyc(($urandom_range(7) == 0), ($urandom_range(59) == 0), ($urandom_range(299) == 0),
          ($urandom_range(2) == 0), CNT_W'($urandom_range(40)), N'($urandom));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
